// File: rtl/knight_pkg.sv
// knight_pkg: shared sprite geometry, animation timing and state types for the knight renderer.
package knight_pkg;
  localparam int SPRITE_W    = 50;
  localparam int SPRITE_H    = 64;
  localparam int NUM_FRAMES  = 4;
  localparam int FRAME_TICKS = 8;
  localparam int ADDR_W      = 14;
  localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;
  localparam int TICK_W      = $clog2(FRAME_TICKS);
  localparam logic [2:0] TRANSPARENT_IDX = 3'd0;
  typedef enum logic {IDLE, WALK} anim_state_t;
endpackage

// File: rtl/knight_anim_fsm.sv
// knight_anim_fsm: per-video-frame walk animation; all state moves only on frame_tick.
module knight_anim_fsm
  import knight_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       walking,
  input  logic       facing_left,
  output logic [1:0] anim_frame,
  output logic       facing_q
);
  anim_state_t       state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [1:0]        anim_frame_n;
  logic              facing_n;
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      anim_frame <= '0;
      facing_q   <= 1'b0;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_cnt_n;
      anim_frame <= anim_frame_n;
      facing_q   <= facing_n;
    end
  always_comb begin
    state_n      = state;
    tick_cnt_n   = tick_cnt;
    anim_frame_n = anim_frame;
    facing_n     = facing_q;
    if (frame_tick) begin
      facing_n = facing_left;
      if (state == IDLE || !walking) begin
        state_n      = walking && state == IDLE ? WALK : IDLE;
        tick_cnt_n   = '0;
        anim_frame_n = '0;
      end else if (tick_cnt == TICK_W'(FRAME_TICKS - 1)) begin
        tick_cnt_n   = '0;
        anim_frame_n = anim_frame == 2'(NUM_FRAMES - 1) ? 2'd0 : anim_frame + 2'd1;
      end else begin
        tick_cnt_n = tick_cnt + TICK_W'(1);
      end
    end
  end
endmodule

// File: rtl/knight_sprite_renderer.sv
// knight_sprite_renderer: box test and mirrored ROM address per pixel, with a 2-stage
// pipeline registering the returned palette index and opacity flag.
module knight_sprite_renderer
  import knight_pkg::*;
(
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              walking,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [2:0]        rom_q,
  output logic [2:0]        sprite_index,
  output logic              sprite_hit,
  output logic [1:0]        anim_frame
);
  logic [10:0]       dx, dy, col;
  logic              in_box, in_box_d1, facing_q;
  logic [ADDR_W-1:0] addr;
  knight_anim_fsm u_anim (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .walking     (walking),
    .facing_left (facing_left),
    .anim_frame  (anim_frame),
    .facing_q    (facing_q)
  );
  // 11-bit differences: a pixel left of / above the corner wraps large and fails the box test
  always_comb begin
    dx     = {1'b0, DrawX} - {1'b0, pos_x};
    dy     = {1'b0, DrawY} - {1'b0, pos_y};
    in_box = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
    col    = facing_q ? 11'(SPRITE_W - 1) - dx : dx;
    addr   = ADDR_W'(anim_frame) * ADDR_W'(FRAME_WORDS) + ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(col);
  end
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      rom_address  <= '0;
      in_box_d1    <= 1'b0;
      sprite_index <= '0;
      sprite_hit   <= 1'b0;
    end else begin
      rom_address  <= in_box ? addr : '0;
      in_box_d1    <= in_box;
      sprite_index <= rom_q;
      sprite_hit   <= in_box_d1 && rom_q != TRANSPARENT_IDX;
    end
endmodule

// File: tb/tb_knight_sprite_renderer.sv
// tb_knight_sprite_renderer: directed table, animation sequences, reset corner case and
// randomized streaming pixels checked against a plain-arithmetic sprite model.
module tb_knight_sprite_renderer;
  localparam int W = 50, H = 64, FRAMES = 4, HOLD = 8;
  logic        vga_clk, reset_n, frame_tick, walking, facing_left;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic [13:0] rom_address;
  logic [2:0]  rom_q, sprite_index;
  logic        sprite_hit;
  logic [1:0]  anim_frame;
  int errors = 0, checks = 0;
  int walk_n = 0;
  bit face_m = 0, zero_rom = 0;

  knight_sprite_renderer dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .walking(walking), .facing_left(facing_left), .rom_address(rom_address),
    .rom_q(rom_q), .sprite_index(sprite_index), .sprite_hit(sprite_hit),
    .anim_frame(anim_frame)
  );

  initial vga_clk = 0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [2:0] rom_fn(input int a);
    return 3'((a * 5 + 1) % 8);
  endfunction
  function automatic int rom_val(input int a);
    return zero_rom ? 0 : int'(rom_fn(a));
  endfunction
  assign rom_q = zero_rom ? 3'd0 : rom_fn(int'(rom_address));

  // walk frame from the count of consecutive walking ticks since leaving idle
  function automatic int model_frame();
    return walk_n == 0 ? 0 : ((walk_n - 1) / HOLD) % FRAMES;
  endfunction
  function automatic bit model_in(input int x, y, px, py);
    return (x - px) >= 0 && (x - px) < W && (y - py) >= 0 && (y - py) < H;
  endfunction
  function automatic int model_addr(input int x, y, px, py);
    if (!model_in(x, y, px, py)) return 0;
    return model_frame() * W * H + (y - py) * W + (face_m ? W - 1 - (x - px) : (x - px));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input bit w, input bit f);
    walking = w; facing_left = f; frame_tick = 1;
    @(posedge vga_clk); #1;
    frame_tick = 0;
    walk_n = w ? walk_n + 1 : 0;
    face_m = f;
  endtask

  task automatic run_px(input int x, y, ea, input bit ib, input string nm);
    DrawX = 10'(x); DrawY = 10'(y);
    @(posedge vga_clk); #1;
    chk({nm, "_addr"}, rom_address, ea);
    @(posedge vga_clk); #1;
    chk({nm, "_hit"}, sprite_hit, ib && rom_val(ea) != 0);
    chk({nm, "_idx"}, sprite_index, rom_val(ea));
  endtask

  task automatic model_px(input int x, y, input string nm);
    run_px(x, y, model_addr(x, y, pos_x, pos_y), model_in(x, y, pos_x, pos_y), nm);
  endtask

  typedef struct { int x, y; bit face; int addr; bit inb; } vec_t;
  vec_t tbl[10];

  initial begin
    int px, py, x, y, ea, pea;
    bit ib, pib;
    tbl[0] = '{100, 200, 0, 0, 1};    tbl[1] = '{149, 263, 0, 3199, 1};
    tbl[2] = '{150, 200, 0, 0, 0};    tbl[3] = '{99, 200, 0, 0, 0};
    tbl[4] = '{100, 264, 0, 0, 0};    tbl[5] = '{124, 210, 0, 524, 1};
    tbl[6] = '{100, 200, 1, 49, 1};   tbl[7] = '{149, 200, 1, 0, 1};
    tbl[8] = '{124, 210, 1, 525, 1};  tbl[9] = '{150, 263, 1, 0, 0};
    reset_n = 0; frame_tick = 0; walking = 0; facing_left = 0;
    DrawX = 0; DrawY = 0; pos_x = 100; pos_y = 200;
    #23;
    chk("rst_addr", rom_address, 0);
    chk("rst_hit", sprite_hit, 0);
    chk("rst_idx", sprite_index, 0);
    chk("rst_frame", anim_frame, 0);
    @(negedge vga_clk); reset_n = 1;
    @(posedge vga_clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].face != face_m) tick(0, tbl[i].face);
      run_px(tbl[i].x, tbl[i].y, tbl[i].addr, tbl[i].inb, $sformatf("tbl%0d", i));
    end

    tick(0, 0);
    for (int t = 1; t <= 33; t++) begin
      tick(1, 0);
      chk($sformatf("walk_t%0d", t), anim_frame, model_frame());
      if (t == 9) run_px(100, 200, 3200, 1, "frame1_origin");
      repeat (2) @(posedge vga_clk);
      #1;
    end
    chk("walk_wrap", anim_frame, 0);

    for (int t = 0; t < 40 && model_frame() != 2; t++) tick(1, 0);
    chk("drop_at2", anim_frame, 2);
    walking = 0;
    repeat (5) @(posedge vga_clk);
    #1;
    chk("drop_hold", anim_frame, 2);
    tick(0, 0);
    chk("drop_idle", anim_frame, 0);
    for (int t = 1; t <= 9; t++) begin
      tick(1, 0);
      chk($sformatf("rewalk_t%0d", t), anim_frame, model_frame());
    end
    chk("rewalk_adv", anim_frame, 1);

    tick(0, 0);
    zero_rom = 1;
    model_px(100, 200, "zrom_a");
    model_px(130, 240, "zrom_b");
    zero_rom = 0;

    px = 100; py = 200; pea = 0; pib = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: begin px = 100; py = 200; end
          1: begin px = 620; py = 470; end
          2: begin px = 1000; py = 1010; end
          default: begin px = $urandom_range(0, 799); py = $urandom_range(0, 524); end
        endcase
        pos_x = 10'(px); pos_y = 10'(py);
      end
      x = ((px + $urandom_range(0, 70) - 10) % 800 + 800) % 800;
      y = ((py + $urandom_range(0, 80) - 8) % 525 + 525) % 525;
      DrawX = 10'(x); DrawY = 10'(y);
      ea = model_addr(x, y, px, py);
      ib = model_in(x, y, px, py);
      if (i % 41 == 40) begin
        walking = 1'($urandom_range(0, 3) != 0);
        facing_left = 1'($urandom_range(0, 1));
        frame_tick = 1;
      end
      @(posedge vga_clk); #1;
      if (frame_tick) begin
        frame_tick = 0;
        walk_n = walking ? walk_n + 1 : 0;
        face_m = facing_left;
      end
      chk("rnd_addr", rom_address, ea);
      chk("rnd_frame", anim_frame, model_frame());
      if (i > 0) begin
        chk("rnd_hit", sprite_hit, pib && rom_val(pea) != 0);
        chk("rnd_idx", sprite_index, rom_val(pea));
      end
      pea = ea; pib = ib;
    end

    pos_x = 100; pos_y = 200;
    for (int t = 0; t < 9; t++) tick(1, 1);
    DrawX = 110; DrawY = 205;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("pre_rst_hit", sprite_hit, 1);
    reset_n = 0;
    #2;
    chk("async_addr", rom_address, 0);
    chk("async_hit", sprite_hit, 0);
    chk("async_idx", sprite_index, 0);
    chk("async_frame", anim_frame, 0);
    walk_n = 0; face_m = 0;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk); reset_n = 1;
    @(posedge vga_clk); #1;
    chk("rel1_addr", rom_address, model_addr(110, 205, 100, 200));
    chk("rel1_hit", sprite_hit, 0);
    @(posedge vga_clk); #1;
    chk("rel2_hit", sprite_hit, rom_val(260) != 0);
    chk("rel2_idx", sprite_index, rom_val(260));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/knight_sprite_renderer.md
# knight_sprite_renderer

Positioned, animated sprite-address generator sitting directly upstream of the knight sprite ROM and palette. Per pixel, it decides whether (DrawX, DrawY) falls inside the knight's bounding box and computes the ROM address for the current walk frame, mirrored when the knight faces left. It registers the returned palette index with a transparency flag for the downstream colour mux. A per-video-frame animation FSM advances walk frames, and all animation state changes only on frame boundaries.

## Interface
- SPRITE_W, 50: sprite width in pixels
- SPRITE_H, 64: sprite height in pixels
- NUM_FRAMES, 4: walk frames stored back-to-back in ROM, each SPRITE_W*SPRITE_H words
- FRAME_TICKS, 8: video frames each walk frame is held
- ADDR_W, 14: ROM address width; must hold NUM_FRAMES*SPRITE_W*SPRITE_H-1
- vga_clk  in  1  pixel clock; all state on posedge
- reset_n  in  1  reset: one clock; reset is asynchronous and active-low
- frame_tick  in  1  one-cycle pulse per video frame, at vertical-blank start
- DrawX, DrawY  in  10 each  current pixel coordinate, 0..799 / 0..524 including blanking
- pos_x, pos_y  in  10 each  sprite top-left corner, screen coordinates
- walking  in  1  knight moving; sampled only on frame_tick
- facing_left  in  1  horizontal mirror request; sampled only on frame_tick
- rom_address  out  ADDR_W  registered address to the sprite ROM
- rom_q  in  3  ROM data, valid one vga_clk after rom_address
- sprite_index  out  3  registered palette index
- sprite_hit  out  1  registered; 1 = inside box and index non-zero (opaque)
- anim_frame  out  2  current walk frame, for debug and verification

## Operation
- Box test, combinational:
  - dx = DrawX - pos_x and dy = DrawY - pos_y, both 11-bit unsigned. Negative differences wrap to large values and fail the test.
  - in_box = (dx < SPRITE_W) && (dy < SPRITE_H).
- Column: col = facing_q ? SPRITE_W-1-dx : dx. Row: row = dy.
- Address = anim_frame*SPRITE_W*SPRITE_H + row*SPRITE_W + col.
  - Multiplies are by constants.
  - Computed at ADDR_W bits with no truncation inside the legal range.
- When not in_box, rom_address is driven to 0. This is don't-care data, but deterministic.
- Index 0 is transparent. Transparent pixels give sprite_hit=0; sprite_index still shows rom_q.
- Animation FSM, with states IDLE and WALK. All transitions happen only on a cycle with frame_tick=1.
  - IDLE: anim_frame=0, tick_cnt=0. If walking → WALK, with anim_frame staying 0 for this tick.
  - WALK, walking=1: tick_cnt increments. At FRAME_TICKS-1, tick_cnt wraps to 0 and anim_frame advances mod NUM_FRAMES (3 → 0).
  - WALK, walking=0: → IDLE, anim_frame=0, tick_cnt=0.
- facing_q <= facing_left on every frame_tick, in either state.
- Pos_x/pos_y are used live. The upstream block updates them only during vertical blank.
- Reset values: state IDLE, tick_cnt 0, anim_frame 0, facing_q 0, rom_address 0, sprite_index 0, sprite_hit 0, and the in_box pipeline bit 0.

## Timing
- Cycle n: DrawX/DrawY presented.
- Cycle n+1: rom_address and in_box_d1 registered. The ROM samples the address on this edge (or its negedge) and returns rom_q within the cycle.
- Cycle n+2: sprite_index <= rom_q and sprite_hit <= in_box_d1 && (rom_q != 0).
- Total latency DrawX → sprite_hit is 2 vga_clk. The downstream mux delays its background path by 2 to match.
- frame_tick effects (anim_frame, facing_q) appear on the cycle after the pulse.
- Asserting reset_n low mid-line clears outputs immediately. The pipeline refills 2 cycles after release; no stale hit is ever emitted.
- frame_tick held high for several cycles is illegal and need not be handled.

## Structure
- knight_pkg holds:
  - the sprite dimension, frame-count and tick constants;
  - the anim_state_t enum (IDLE, WALK);
  - the transparent-index constant, 0.
- Natural sub-module: knight_anim_fsm, containing state, tick_cnt, anim_frame and facing_q.
- The top holds the box test, address arithmetic and the 2-stage pipeline. The ROM is external.

## Test plan
- Reset then pos=(100,200), facing 0, frame 0:
  - DrawX=100, DrawY=200 → rom_address=0 at n+1.
  - DrawX=149, DrawY=263 → rom_address=3199.
  - DrawX=150 → sprite_hit=0 at n+2.
- facing_left=1 latched by frame_tick, pos (100,200): DrawX=100, DrawY=200 → rom_address=49; DrawX=149 → rom_address=0.
- walking=1 for 33 frame_ticks → anim_frame goes 0 (ticks 1-8), 1, 2, 3, then 0. In frame 1, pixel (0,0) of the box → rom_address=3200.
- walking drops mid-animation at anim_frame=2 → unchanged until next frame_tick, then anim_frame=0 and tick_cnt=0.
- pos_x=620 (box partly off-screen) and pos_x=1000-wrap case → no spurious hits outside the box. ROM model returns 0 inside the box → sprite_hit=0 with sprite_index=0.
- reset_n pulsed low mid-sprite-line → all outputs 0 asynchronously. First sprite_hit=1 appears no earlier than 2 cycles after release.
